lcd_instruction_queue_sender: RTL and testbench
===============================================

// Module: lcd_instruction_queue_sender
// PURPOSE
//  Parametrised next-generation LCD instruction sender. Front-end FIFO accepts {init_mode, RS, RW, data[7:0]} entries over
//  a valid/ready handshake; back-end FSM drives an HD44780-class bus (4- or 8-bit) with parametrised setup/E-pulse/hold
//  timing, a nibble gap, and per-command completion wait (long wait for clear/home). Sits between LCD controller FSM and pads.
// PARAMETERS
//  DB_WIDTH     4      data bus width, 4 or 8 (8: byte sent in one E pulse, init_mode ignored)
//  FIFO_DEPTH   4      entries, power of 2, >=2
//  T_SETUP      2      cycles RS/RW/DB stable before E rises (>=1)
//  T_PULSE      12     cycles E high (>=1)
//  T_HOLD       1      cycles RS/RW/DB held after E falls (>=1)
//  T_NIBBLE_GAP 50     idle cycles between upper and lower nibble (>=1)
//  T_CMD_WAIT   2000   cycles after last transfer, normal command
//  T_LONG_WAIT  82000  cycles after last transfer, clear display / return home
// PORTS
//  clk               in   1         rising-edge clock
//  reset             in   1         synchronous, active-high
//  instruction_valid in   1         entry offered this cycle
//  instruction       in   10        [9]=RS, [8]=RW, [7:0]=data
//  init_mode         in   1         sampled with instruction: send upper nibble only
//  instruction_ready out  1         FIFO not full; transfer when valid&&ready
//  LCD_RS            out  1         register select
//  LCD_RW            out  1         read/write (driven from entry, no readback)
//  LCD_E             out  1         enable strobe
//  DB                out  DB_WIDTH  data bus
//  busy              out  1         FIFO non-empty or FSM not IDLE
//  fifo_level        out  $clog2(FIFO_DEPTH)+1  entries held
// BEHAVIOUR
//  - Reset: LCD_RS/LCD_RW/LCD_E=0, DB=0, busy=0, fifo_level=0, instruction_ready=1, FSM=IDLE, FIFO flushed, counters 0.
//    Reset mid-operation aborts immediately: E low at next edge, pending entries discarded.
//  - FIFO: push on valid&&ready; pop only by FSM in IDLE when non-empty. Push+pop same cycle: level unchanged.
//    Full: ready=0, offered entry not taken (no overwrite). Pointers wrap mod FIFO_DEPTH.
//  - Latency: entry accepted at edge t -> popped at edge t+1 -> RS/RW/DB valid from cycle after t+1, E rises T_SETUP later.
//  - FSM states: IDLE -> SETUP(T_SETUP) -> PULSE(E=1, T_PULSE) -> HOLD(T_HOLD) ->
//      second nibble pending ? GAP(T_NIBBLE_GAP, E=0) -> SETUP : WAIT -> IDLE.
//    RS/RW constant for whole entry; DB changes only on entry to SETUP. E is 1 only in PULSE.
//  - 4-bit: DB=data[7:4] then data[3:0]; init_mode=1 sends data[7:4] only (one pulse). 8-bit: DB=data[7:0], one pulse.
//  - WAIT length: T_LONG_WAIT if RS=0, RW=0, data[7:2]==0, data[1:0]!=0 (clear 0x01, home 0x02/0x03); else T_CMD_WAIT.
//  - Wait counter: one down-counter, width $clog2(max(all T_*)+1), loaded with T-1 on state entry; state exits at 0.
//  - busy high from cycle after accept until WAIT done and FIFO empty; back-to-back entries pop directly from WAIT->IDLE->SETUP.
//  - Outputs registered; DB/RS/RW hold last values in IDLE (not returned to 0).
// STRUCTURE
//  - lcd_pkg: FSM state enum (IDLE,SETUP,PULSE,HOLD,GAP,WAIT), default timing constants, CMD_CLEAR=8'h01, CMD_HOME=8'h02.
//  - Sub-module lcd_cmd_fifo (sync FIFO, WIDTH=11, DEPTH=FIFO_DEPTH, full/empty/level); FSM + counter in top.
// TESTING (defaults, 20 ns clock)
//  - 4-bit 10'b00_0010_1101, init_mode=0 -> DB=4'h2 E 12 cycles, 50-cycle gap, DB=4'hD E 12 cycles, RS=0, busy 2000 more.
//  - init_mode=1, 10'b00_0011_0000 -> exactly one E pulse with DB=4'h3; WAIT 2000 cycles; busy drops after.
//  - 10'b00_0000_0001 (clear) -> two pulses, then busy held 82000 cycles; 10'b10_0000_0001 (RS=1) -> 2000 only.
//  - FIFO_DEPTH=4, valid held 6 cycles while FSM busy -> 4 accepted, ready=0 after, fifo_level=4, all sent in order.
//  - Reset asserted during PULSE -> next cycle E=0, DB=0, busy=0, fifo_level=0, ready=1; queued entries never appear.
//  - DB_WIDTH=8, 10'b11_1010_1010 -> single pulse DB=8'hAA, RS=1, RW=1; init_mode ignored.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD instruction sender: FSM states, default timing,
// and the command decode that picks the long completion wait.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    GAP,
    WAIT
  } lcd_state_t;

  localparam int DEF_T_SETUP      = 2;
  localparam int DEF_T_PULSE      = 12;
  localparam int DEF_T_HOLD       = 1;
  localparam int DEF_T_NIBBLE_GAP = 50;
  localparam int DEF_T_CMD_WAIT   = 2000;
  localparam int DEF_T_LONG_WAIT  = 82000;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clear display and return home (0x01..0x03 with RS=RW=0) need the long settle time.
  function automatic logic is_long_cmd(input logic rs, input logic rw, input logic [7:0] dat);
    return !rs && !rw && ((dat & ~(CMD_CLEAR | CMD_HOME)) == 8'h00) &&
           ((dat & (CMD_CLEAR | CMD_HOME)) != 8'h00);
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous FIFO holding {init_mode, RS, RW, data}; pushes are dropped when full and
// pops are ignored when empty, so the level never over- or underflows.
module lcd_cmd_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lcd_instruction_queue_sender.sv
// Queues LCD instructions and plays them out on an HD44780-style bus (4- or 8-bit) with
// setup/E-pulse/hold timing, a nibble gap and a per-command completion wait.
module lcd_instruction_queue_sender
  import lcd_pkg::*;
#(
  parameter int DB_WIDTH     = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int T_SETUP      = DEF_T_SETUP,
  parameter int T_PULSE      = DEF_T_PULSE,
  parameter int T_HOLD       = DEF_T_HOLD,
  parameter int T_NIBBLE_GAP = DEF_T_NIBBLE_GAP,
  parameter int T_CMD_WAIT   = DEF_T_CMD_WAIT,
  parameter int T_LONG_WAIT  = DEF_T_LONG_WAIT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          instruction_valid,
  input  logic [9:0]                    instruction,
  input  logic                          init_mode,
  output logic                          instruction_ready,
  output logic                          LCD_RS,
  output logic                          LCD_RW,
  output logic                          LCD_E,
  output logic [DB_WIDTH-1:0]           DB,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int T_MAX = max_of(max_of(max_of(T_SETUP, T_PULSE), max_of(T_HOLD, T_NIBBLE_GAP)),
                                max_of(T_CMD_WAIT, T_LONG_WAIT));
  localparam int CW = $clog2(T_MAX + 1);

  localparam logic [CW-1:0] C_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] C_PULSE = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] C_HOLD  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] C_GAP   = CW'(T_NIBBLE_GAP - 1);
  localparam logic [CW-1:0] C_CMD   = CW'(T_CMD_WAIT - 1);
  localparam logic [CW-1:0] C_LONG  = CW'(T_LONG_WAIT - 1);

  logic [10:0] pop_data;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;

  lcd_cmd_fifo #(
    .WIDTH (11),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (instruction_valid),
    .push_data ({init_mode, instruction}),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  lcd_state_t          state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic                e_n, rs_n, rw_n;
  logic [DB_WIDTH-1:0] db_n;
  logic [7:0]          dat_q, dat_n;
  logic                init_q, init_n;
  logic                low_q, low_n;
  logic [DB_WIDTH-1:0] db_first;
  logic [DB_WIDTH-1:0] db_second;
  logic                second_pending;

  if (DB_WIDTH == 8) begin : g_db8
    assign db_first  = pop_data[7:0];
    assign db_second = dat_q;
  end else begin : g_db4
    assign db_first  = pop_data[7:4];
    assign db_second = dat_q[3:0];
  end

  assign second_pending    = (DB_WIDTH == 4) && !init_q && !low_q;
  assign instruction_ready = !fifo_full;
  assign busy              = (state != IDLE) || !fifo_empty;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    e_n     = 1'b0;
    rs_n    = LCD_RS;
    rw_n    = LCD_RW;
    db_n    = DB;
    dat_n   = dat_q;
    init_n  = init_q;
    low_n   = low_q;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = SETUP;
          cnt_n   = C_SETUP;
          init_n  = pop_data[10];
          rs_n    = pop_data[9];
          rw_n    = pop_data[8];
          dat_n   = pop_data[7:0];
          db_n    = db_first;
          low_n   = 1'b0;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_n = PULSE;
          cnt_n   = C_PULSE;
          e_n     = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_n = HOLD;
          cnt_n   = C_HOLD;
        end else begin
          cnt_n = cnt - 1'b1;
          e_n   = 1'b1;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          if (second_pending) begin
            state_n = GAP;
            cnt_n   = C_GAP;
          end else begin
            state_n = WAIT;
            cnt_n   = is_long_cmd(LCD_RS, LCD_RW, dat_q) ? C_LONG : C_CMD;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_n = SETUP;
          cnt_n   = C_SETUP;
          db_n    = db_second;
          low_n   = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      WAIT: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Bus outputs are registered; DB/RS/RW keep their last value while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      LCD_E  <= 1'b0;
      LCD_RS <= 1'b0;
      LCD_RW <= 1'b0;
      DB     <= '0;
      dat_q  <= '0;
      init_q <= 1'b0;
      low_q  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      LCD_E  <= e_n;
      LCD_RS <= rs_n;
      LCD_RW <= rw_n;
      DB     <= db_n;
      dat_q  <= dat_n;
      init_q <= init_n;
      low_q  <= low_n;
    end
  end

endmodule

// File: tb/tb_lcd_instruction_queue_sender.sv
// Directed bench: stimulus queues expected E pulses, a monitor checks each pulse and the gaps around it.
module tb_lcd_instruction_queue_sender;

  localparam int SU = 2, PW = 12, HO = 1, GP = 50, CWT = 200, LWT = 820;
  // Cycles E stays low after a pulse before the next event.
  localparam int L_NIB  = 53;   // HO + GP + SU, then next nibble
  localparam int L_CMD  = 201;  // HO + CWT, then busy drops
  localparam int L_LONG = 821;  // HO + LWT, then busy drops
  localparam int L_B2B  = 204;  // HO + CWT + 1 idle + SU, then next entry

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld = 1'b0;
  logic [9:0] ins = '0;
  logic       im  = 1'b0;
  logic       use8 = 1'b0;

  logic       rdy4, rs4, rw4, e4, busy4;
  logic [3:0] db4;
  logic [2:0] lvl4;
  logic       rdy8, rs8, rw8, e8, busy8;
  logic [7:0] db8;
  logic [2:0] lvl8;

  int compared   = 0;
  int mismatched = 0;

  always #10 clk = ~clk;

  lcd_instruction_queue_sender #(
    .DB_WIDTH(4), .FIFO_DEPTH(4), .T_SETUP(SU), .T_PULSE(PW), .T_HOLD(HO),
    .T_NIBBLE_GAP(GP), .T_CMD_WAIT(CWT), .T_LONG_WAIT(LWT)
  ) dut4 (
    .clk(clk), .reset(rst), .instruction_valid(vld && !use8), .instruction(ins),
    .init_mode(im), .instruction_ready(rdy4), .LCD_RS(rs4), .LCD_RW(rw4), .LCD_E(e4),
    .DB(db4), .busy(busy4), .fifo_level(lvl4)
  );

  lcd_instruction_queue_sender #(
    .DB_WIDTH(8), .FIFO_DEPTH(4), .T_SETUP(SU), .T_PULSE(PW), .T_HOLD(HO),
    .T_NIBBLE_GAP(GP), .T_CMD_WAIT(CWT), .T_LONG_WAIT(LWT)
  ) dut8 (
    .clk(clk), .reset(rst), .instruction_valid(vld && use8), .instruction(ins),
    .init_mode(im), .instruction_ready(rdy8), .LCD_RS(rs8), .LCD_RW(rw8), .LCD_E(e8),
    .DB(db8), .busy(busy8), .fifo_level(lvl8)
  );

  logic       m_e, m_rs, m_rw, m_busy, m_rdy;
  logic [7:0] m_db;
  logic [2:0] m_lvl;
  assign m_e    = use8 ? e8 : e4;
  assign m_rs   = use8 ? rs8 : rs4;
  assign m_rw   = use8 ? rw8 : rw4;
  assign m_busy = use8 ? busy8 : busy4;
  assign m_rdy  = use8 ? rdy8 : rdy4;
  assign m_db   = use8 ? db8 : {4'h0, db4};
  assign m_lvl  = use8 ? lvl8 : lvl4;

  typedef struct {
    logic [7:0] db;
    logic       rs;
    logic       rw;
    int         low;
    logic       drop;
  } exp_t;
  exp_t expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_pulse(input logic [7:0] db, input logic rs, input logic rw,
                              input int low, input logic drop);
    exp_t x;
    x.db = db; x.rs = rs; x.rw = rw; x.low = low; x.drop = drop;
    expq.push_back(x);
  endtask

  task automatic send(input logic [9:0] i, input logic m);
    int n = 0;
    ins = i; im = m; vld = 1'b1;
    while (!m_rdy && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    vld = 1'b0;
    chk("send_accept_timeout", (n >= 1000), 0);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (m_busy && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_idle_timeout"}, (n >= 3000), 0);
    chk({name, "_all_pulses_seen"}, expq.size(), 0);
  endtask

  // Monitor: checks each E pulse against the expected queue, its width, and the low time after it.
  initial begin : monitor
    exp_t cur;
    bit   e_prev = 1'b0;
    bit   measuring = 1'b0;
    int   high = 0;
    int   low = 0;
    cur.db = '0; cur.rs = 1'b0; cur.rw = 1'b0; cur.low = 0; cur.drop = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        e_prev = 1'b0;
        measuring = 1'b0;
        high = 0;
      end else begin
        if (m_e && !e_prev) begin
          if (measuring) begin
            chk("low_cycles_before_pulse", low, cur.low);
            chk("next_pulse_vs_busy_drop", 1'b0, cur.drop);
            measuring = 1'b0;
          end
          chk("pulse_was_expected", (expq.size() > 0), 1);
          if (expq.size() > 0) cur = expq.pop_front();
          else begin
            cur.db = m_db; cur.rs = m_rs; cur.rw = m_rw; cur.low = 0; cur.drop = 1'b1;
          end
          chk("pulse_db", m_db, cur.db);
          chk("pulse_rs", m_rs, cur.rs);
          chk("pulse_rw", m_rw, cur.rw);
          high = 1;
        end else if (m_e) begin
          high++;
        end else if (e_prev) begin
          chk("pulse_width", high, PW);
          chk("hold_db", m_db, cur.db);
          chk("hold_rs", m_rs, cur.rs);
          low = 1;
          measuring = 1'b1;
        end else if (measuring) begin
          if (m_busy) low++;
          else begin
            chk("low_cycles_before_idle", low, cur.low);
            chk("busy_drop_vs_next_pulse", 1'b1, cur.drop);
            measuring = 1'b0;
          end
        end
        e_prev = m_e;
      end
    end
  end

  initial begin : stimulus
    int n;
    int pulses;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_e", e4, 0);
    chk("rst_rs", rs4, 0);
    chk("rst_rw", rw4, 0);
    chk("rst_db4", db4, 0);
    chk("rst_db8", db8, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_level", lvl4, 0);
    chk("rst_ready", rdy4, 1);

    // Two-nibble write of 0x2D, plus accept-to-E latency.
    expect_pulse(8'h02, 0, 0, L_NIB, 0);
    expect_pulse(8'h0D, 0, 0, L_CMD, 1);
    send(10'b00_0010_1101, 1'b0);
    chk("busy_after_accept", m_busy, 1);
    n = 0;
    while (!m_e && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_to_e_rise_cycles", n, 1 + SU);
    wait_idle("nibble_pair");

    // init_mode: upper nibble only.
    expect_pulse(8'h03, 0, 0, L_CMD, 1);
    send(10'b00_0011_0000, 1'b1);
    wait_idle("init_mode");

    // Long-wait decode: clear, home 0x03, then RS=1 and 0x04 use the normal wait.
    expect_pulse(8'h00, 0, 0, L_NIB, 0);
    expect_pulse(8'h01, 0, 0, L_LONG, 1);
    send(10'b00_0000_0001, 1'b0);
    wait_idle("clear");
    expect_pulse(8'h00, 0, 0, L_NIB, 0);
    expect_pulse(8'h03, 0, 0, L_LONG, 1);
    send(10'b00_0000_0011, 1'b0);
    wait_idle("home");
    expect_pulse(8'h00, 1, 0, L_NIB, 0);
    expect_pulse(8'h01, 1, 0, L_CMD, 1);
    send(10'b10_0000_0001, 1'b0);
    wait_idle("rs_data_01");
    expect_pulse(8'h00, 0, 0, L_NIB, 0);
    expect_pulse(8'h04, 0, 0, L_CMD, 1);
    send(10'b00_0000_0100, 1'b0);
    wait_idle("cmd_04");

    // FIFO fill: A is popped at once, then valid held 6 cycles -> only E1..E4 taken.
    expect_pulse(8'h0A, 1, 0, L_B2B, 0);
    for (int k = 1; k <= 3; k++) expect_pulse(8'(k), 1, 0, L_B2B, 0);
    expect_pulse(8'h04, 1, 0, L_CMD, 1);
    send(10'b10_1010_0000, 1'b1);
    vld = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      ins = 10'h200 | 10'(k << 4);
      if (k == 2) chk("level_push_pop_same_cycle", m_lvl, 1);
      @(posedge clk); #1;
    end
    vld = 1'b0;
    chk("full_level", m_lvl, 4);
    chk("full_ready", m_rdy, 0);
    wait_idle("fifo_fill");

    // Reset during the first pulse discards everything queued behind it.
    expect_pulse(8'h02, 0, 0, L_NIB, 0);
    send(10'b00_0010_1101, 1'b0);
    send(10'b10_1111_0000, 1'b1);
    send(10'b10_1110_0000, 1'b1);
    n = 0;
    while (!m_e && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("reset_test_e_seen", m_e, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_e", m_e, 0);
    chk("abort_db", m_db, 0);
    chk("abort_rs", m_rs, 0);
    chk("abort_busy", m_busy, 0);
    chk("abort_level", m_lvl, 0);
    chk("abort_ready", m_rdy, 1);
    pulses = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (m_e) pulses++;
    end
    chk("abort_no_more_pulses", pulses, 0);
    chk("abort_queue_empty", expq.size(), 0);

    // 8-bit bus: whole byte in one pulse, init_mode ignored.
    use8 = 1'b1;
    @(posedge clk); #1;
    expect_pulse(8'hAA, 1, 1, L_CMD, 1);
    send(10'b11_1010_1010, 1'b1);
    wait_idle("bus8_aa");
    expect_pulse(8'h01, 0, 0, L_LONG, 1);
    send(10'b00_0000_0001, 1'b0);
    wait_idle("bus8_clear");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
